uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

Parametrised command decoder between the UART receiver and the game control logic, replacing the fixed three-code multiplayer comparator. It accepts received bytes qualified by a valid strobe, matches them against NUM_CMDS configurable codes, either as single bytes or as protected three-byte frames, and emits one-cycle command pulses plus sticky flags. It also reports malformed frames and maintains a link-alive watchdog on the opponent's byte stream.

## Interface
- NUM_CMDS, 3: number of recognised command codes (1..8)
- CMD_CODES, {8'h52, 8'h44, 8'h4C}: packed 8*NUM_CMDS-bit code table; code i is bits [8i+7:8i] (defaults: 0 = 'L' victory, 1 = 'D' opponent hit, 2 = 'R' opponent ready)
- FRAMED, 0: 0 = single-byte mode; 1 = frame mode HDR, CMD, ~CMD
- HDR_CHAR, 8'h23: frame header byte ('#')
- FRAME_TIMEOUT, 1000: max cycles between frame bytes (>= 2)
- LINK_TIMEOUT, 65000000: cycles without rx_valid before link_alive drops (>= 1)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- enable  in  1  decoder active (multiplayer selected)
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- cmd_ack  in  NUM_CMDS  per-command clear of cmd_flag
- cmd_pulse  out  NUM_CMDS  one-cycle strobe per decoded command
- cmd_flag  out  NUM_CMDS  sticky command flags
- frame_err  out  1  one-cycle strobe, malformed or timed-out frame
- link_alive  out  1  a byte was received within LINK_TIMEOUT cycles

One clock domain; reset is synchronous and active-low.

## Operation
- Code match: rx_data compared against all CMD_CODES; duplicate codes resolve to the lowest index; at most one cmd_pulse bit set per cycle.
- Single-byte mode (FRAMED=0): accepted byte matching code i -> cmd_pulse[i]; non-matching bytes ignored, no error.
- Frame mode (FRAMED=1), states IDLE, GOT_HDR, GOT_CMD:
  - IDLE: byte == HDR_CHAR -> GOT_HDR; other bytes ignored.
  - GOT_HDR: byte == HDR_CHAR -> stay (repeated header tolerated); byte matching code i -> latch i, GOT_CMD; otherwise frame_err, IDLE.
  - GOT_CMD: byte == ~CMD_CODES[i] -> cmd_pulse[i], IDLE; otherwise frame_err, then GOT_HDR if byte == HDR_CHAR, else IDLE.
  - Timeout counter clears on every accepted byte; in GOT_HDR/GOT_CMD, reaching FRAME_TIMEOUT cycles without a byte -> frame_err, IDLE. Counter idle (zero) in IDLE.
- Byte accepted only when enable=1 and rx_valid=1.
- cmd_flag[i]: set by cmd_pulse[i], cleared by cmd_ack[i]; set wins over simultaneous ack.
- enable=0: FSM forced to IDLE, timeout counter cleared, no pulses, no frame_err, cmd_flag cleared; link watchdog keeps running.
- Link watchdog: saturating counter, cleared by any rx_valid (independent of enable), otherwise increments up to LINK_TIMEOUT; link_alive = (count < LINK_TIMEOUT).

## Timing
- All outputs registered.
- Reset (rst_n=0 at a clk edge): FSM IDLE, cmd_pulse=0, cmd_flag=0, frame_err=0, timeout counter 0, link counter = LINK_TIMEOUT, so link_alive=0.
- Single-byte latency: rx_valid at edge N -> cmd_pulse high during cycle N+1 only; cmd_flag high from N+1.
- Frame latency: complement byte at edge N -> cmd_pulse during N+1.
- frame_err: high for exactly the one cycle after the offending byte or timeout edge.
- link_alive: rises the cycle after rx_valid; falls LINK_TIMEOUT cycles after the last rx_valid.
- Back-to-back rx_valid on consecutive cycles are all processed; no byte is dropped.
- Reset mid-frame: discards the partial frame; no pulse or error generated.

## Test plan
- FRAMED=0, enable=1, rx_data=8'h4C for one cycle -> cmd_pulse=3'b001 for one cycle; cmd_flag[0]=1 until cmd_ack[0]; 8'h41 -> no response.
- FRAMED=1: bytes 8'h23, 8'h44, 8'hBB -> cmd_pulse=3'b010 one cycle after 8'hBB; bytes 8'h23, 8'h44, 8'h44 -> frame_err one cycle, no pulse.
- FRAMED=1, FRAME_TIMEOUT=10: 8'h23 then silence -> frame_err at cycle 10, FSM IDLE; a following 8'h52 alone -> no pulse.
- enable=0 with 8'h52 strobed -> no pulse; cmd_flag set earlier is cleared; link_alive still rises.
- LINK_TIMEOUT=5: one rx_valid -> link_alive=1 next cycle, drops 5 cycles later; reset -> link_alive=0.
- cmd_ack[1] asserted in the same cycle cmd_pulse[1] sets the flag -> cmd_flag[1] remains 1.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// Received-byte stream from the UART receiver into the command decoder.
// rx_valid qualifies rx_data for exactly one clock.
interface uart_cmd_decoder_if;
   logic       rx_valid;
   logic [7:0] rx_data;

   modport master (output rx_valid, output rx_data);
   modport slave  (input  rx_valid, input  rx_data);
endinterface

// File: rtl/uart_cmd_decoder.sv
// Decodes opponent command bytes (single-byte or HDR/CMD/~CMD frames)
// into pulses, sticky flags, frame errors and a link-alive watchdog.
module uart_cmd_decoder #(
   parameter int                     NUM_CMDS      = 3,
   parameter logic [8*NUM_CMDS-1:0] CMD_CODES     = {8'h52, 8'h44, 8'h4C},
   parameter bit                     FRAMED        = 1'b0,
   parameter logic [7:0]             HDR_CHAR      = 8'h23,
   parameter int                     FRAME_TIMEOUT = 1000,
   parameter int                     LINK_TIMEOUT  = 65000000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                enable,
   uart_cmd_decoder_if.slave   rx,
   input  logic [NUM_CMDS-1:0] cmd_ack,
   output logic [NUM_CMDS-1:0] cmd_pulse,
   output logic [NUM_CMDS-1:0] cmd_flag,
   output logic                frame_err,
   output logic                link_alive
);

   localparam int IW = (NUM_CMDS > 1) ? $clog2(NUM_CMDS) : 1;
   localparam int TW = $clog2(FRAME_TIMEOUT + 1);
   localparam int LW = $clog2(LINK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, GOT_HDR, GOT_CMD} state_t;

   state_t               state;
   state_t               state_n;
   logic [IW-1:0]        cmd_idx;
   logic [IW-1:0]        idx_n;
   logic [IW-1:0]        hit_idx;
   logic                 hit;
   logic [NUM_CMDS-1:0]  hit_oh;
   logic [NUM_CMDS-1:0]  cmd_oh;
   logic [NUM_CMDS-1:0]  fire;
   logic [7:0]           cpl;
   logic                 bad;
   logic                 accept;
   logic                 tmo;
   logic                 is_hdr;
   logic [TW-1:0]        tcnt;
   logic [LW-1:0]        lcnt;

   assign accept = enable & rx.rx_valid;
   assign is_hdr = (rx.rx_data == HDR_CHAR);
   assign tmo    = (state != IDLE) &&
                   (tcnt == TW'(FRAME_TIMEOUT - 1));

   // Descending scan so the lowest matching index wins.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_CMDS - 1; i >= 0; i--) begin
         if (rx.rx_data == CMD_CODES[8*i +: 8]) begin
            hit     = 1'b1;
            hit_idx = IW'(i);
         end
      end
   end

   always_comb begin
      hit_oh = '0;
      cmd_oh = '0;
      cpl    = '0;
      for (int i = 0; i < NUM_CMDS; i++) begin
         hit_oh[i] = hit && (hit_idx == IW'(i));
         cmd_oh[i] = (cmd_idx == IW'(i));
         if (cmd_idx == IW'(i)) cpl = ~CMD_CODES[8*i +: 8];
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = cmd_idx;
      fire    = '0;
      bad     = 1'b0;
      if (!FRAMED) begin
         if (accept) fire = hit_oh;
      end else if (accept) begin
         unique case (state)
            IDLE: begin
               if (is_hdr) state_n = GOT_HDR;
            end
            GOT_HDR: begin
               if (is_hdr) begin
                  state_n = GOT_HDR;
               end else if (hit) begin
                  idx_n   = hit_idx;
                  state_n = GOT_CMD;
               end else begin
                  bad     = 1'b1;
                  state_n = IDLE;
               end
            end
            GOT_CMD: begin
               if (rx.rx_data == cpl) begin
                  fire    = cmd_oh;
                  state_n = IDLE;
               end else begin
                  bad     = 1'b1;
                  state_n = is_hdr ? GOT_HDR : IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (tmo) begin
         bad     = 1'b1;
         state_n = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || !enable) begin
         state     <= IDLE;
         cmd_idx   <= '0;
         tcnt      <= '0;
         cmd_pulse <= '0;
         cmd_flag  <= '0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         cmd_idx   <= idx_n;
         cmd_pulse <= fire;
         frame_err <= bad;
         cmd_flag  <= (cmd_flag & ~cmd_ack) | fire;
         if (accept || state_n == IDLE) tcnt <= '0;
         else                           tcnt <= tcnt + 1'b1;
      end
   end

   // Watchdog ignores enable so the link can be judged before play starts.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lcnt       <= LW'(LINK_TIMEOUT);
         link_alive <= 1'b0;
      end else if (rx.rx_valid) begin
         lcnt       <= '0;
         link_alive <= 1'b1;
      end else if (lcnt != LW'(LINK_TIMEOUT)) begin
         lcnt       <= lcnt + 1'b1;
         link_alive <= (lcnt != LW'(LINK_TIMEOUT - 1));
      end
   end

endmodule
